// File: rtl/usbdev_aon_wake_seq.sv
// AON wake sequencer: turns software suspend/ack pulses into level-held
// detector handshakes, captures the wake cause and counts wakes.
module usbdev_aon_wake_seq #(
    parameter int unsigned AckTimeout = 16,
    parameter int unsigned CntW       = 8
) (
    input  logic            clk_aon_i,
    input  logic            rst_aon_i,
    input  logic            sw_suspend_req_i,
    input  logic            sw_wake_ack_i,
    input  logic            wake_detect_active_aon_i,
    input  logic            wake_req_aon_i,
    input  logic            bus_not_idle_aon_i,
    input  logic            bus_reset_aon_i,
    input  logic            sense_lost_aon_i,
    output logic            suspend_req_aon_o,
    output logic            wake_ack_aon_o,
    output logic [2:0]      cause_o,
    output logic            cause_valid_o,
    output logic [CntW-1:0] wake_count_o,
    output logic            timeout_err_o,
    output logic            protocol_err_o,
    output logic [2:0]      state_o
);

    localparam int unsigned TmrW    = 8;
    localparam logic [TmrW-1:0] TmrLast = TmrW'(AckTimeout - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_REQ_SUSP = 3'd1,
        ST_ACTIVE   = 3'd2,
        ST_WOKEN    = 3'd3,
        ST_ACK_WAIT = 3'd4
    } state_t;

    state_t            r_state;
    logic [TmrW-1:0]   r_tmr;
    logic              r_suspend_req;
    logic              r_wake_ack;
    logic [2:0]        r_cause;
    logic              r_cause_valid;
    logic [CntW-1:0]   r_wake_count;
    logic              r_timeout_err;
    logic              r_protocol_err;

    logic [2:0]        w_cause_now;
    logic              w_tmr_expired;

    assign w_cause_now   = {sense_lost_aon_i, bus_reset_aon_i, bus_not_idle_aon_i};
    assign w_tmr_expired = (r_tmr == TmrLast);

    always_ff @(posedge clk_aon_i or posedge rst_aon_i) begin
        if (rst_aon_i) begin
            r_state        <= ST_IDLE;
            r_tmr          <= '0;
            r_suspend_req  <= 1'b0;
            r_wake_ack     <= 1'b0;
            r_cause        <= '0;
            r_cause_valid  <= 1'b0;
            r_wake_count   <= '0;
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
        end else begin
            r_timeout_err  <= 1'b0;
            r_protocol_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (sw_suspend_req_i) begin
                        r_state       <= ST_REQ_SUSP;
                        r_suspend_req <= 1'b1;
                        r_cause       <= '0;
                        r_cause_valid <= 1'b0;
                        r_tmr         <= '0;
                    end
                end
                ST_REQ_SUSP: begin
                    // A detector response on the timeout edge takes precedence.
                    if (wake_detect_active_aon_i) begin
                        r_state       <= ST_ACTIVE;
                        r_suspend_req <= 1'b0;
                    end else if (w_tmr_expired) begin
                        r_state       <= ST_IDLE;
                        r_suspend_req <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TmrW'(1);
                    end
                end
                ST_ACTIVE: begin
                    if (!wake_detect_active_aon_i) begin
                        r_state        <= ST_IDLE;
                        r_protocol_err <= 1'b1;
                    end else begin
                        if (wake_req_aon_i) begin
                            r_cause       <= w_cause_now;
                            r_cause_valid <= 1'b1;
                            if (r_wake_count != '1) begin
                                r_wake_count <= r_wake_count + CntW'(1);
                            end
                        end
                        if (sw_wake_ack_i) begin
                            r_state    <= ST_ACK_WAIT;
                            r_wake_ack <= 1'b1;
                            r_tmr      <= '0;
                        end else if (wake_req_aon_i) begin
                            r_state <= ST_WOKEN;
                        end
                    end
                end
                ST_WOKEN: begin
                    if (!wake_detect_active_aon_i) begin
                        r_state        <= ST_IDLE;
                        r_protocol_err <= 1'b1;
                    end else if (sw_wake_ack_i) begin
                        r_state    <= ST_ACK_WAIT;
                        r_wake_ack <= 1'b1;
                        r_tmr      <= '0;
                    end
                end
                ST_ACK_WAIT: begin
                    // Unanswered ack falls back to WOKEN so software can retry.
                    if (!wake_detect_active_aon_i) begin
                        r_state    <= ST_IDLE;
                        r_wake_ack <= 1'b0;
                    end else if (w_tmr_expired) begin
                        r_state       <= ST_WOKEN;
                        r_wake_ack    <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_tmr <= r_tmr + TmrW'(1);
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_suspend_req <= 1'b0;
                    r_wake_ack    <= 1'b0;
                end
            endcase
        end
    end

    assign suspend_req_aon_o = r_suspend_req;
    assign wake_ack_aon_o    = r_wake_ack;
    assign cause_o           = r_cause;
    assign cause_valid_o     = r_cause_valid;
    assign wake_count_o      = r_wake_count;
    assign timeout_err_o     = r_timeout_err;
    assign protocol_err_o    = r_protocol_err;
    assign state_o           = r_state;

endmodule

// File: tb/tb_usbdev_aon_wake_seq.sv
// Bench for usbdev_aon_wake_seq: directed handshake scenarios followed by
// randomized traffic, all checked against a cycle-level reference model.
module tb_usbdev_aon_wake_seq;

    localparam int unsigned ACK_TO = 16;
    localparam int unsigned CW     = 2;
    localparam int          CMAX   = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          sus, ack, act, wreq, bni, brst, slost;
    logic          o_susp, o_ack, o_valid, o_terr, o_perr;
    logic [2:0]    o_cause, o_state;
    logic [CW-1:0] o_count;

    int total = 0;
    int bad   = 0;

    // Reference: "phase" is the debug code the block must report.
    int m_phase, m_age, m_cause, m_count;
    bit m_susp, m_ack, m_valid, m_terr, m_perr;

    always #5 clk = ~clk;

    usbdev_aon_wake_seq #(.AckTimeout(ACK_TO), .CntW(CW)) dut (
        .clk_aon_i               (clk),
        .rst_aon_i               (rst),
        .sw_suspend_req_i        (sus),
        .sw_wake_ack_i           (ack),
        .wake_detect_active_aon_i(act),
        .wake_req_aon_i          (wreq),
        .bus_not_idle_aon_i      (bni),
        .bus_reset_aon_i         (brst),
        .sense_lost_aon_i        (slost),
        .suspend_req_aon_o       (o_susp),
        .wake_ack_aon_o          (o_ack),
        .cause_o                 (o_cause),
        .cause_valid_o           (o_valid),
        .wake_count_o            (o_count),
        .timeout_err_o           (o_terr),
        .protocol_err_o          (o_perr),
        .state_o                 (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_age = 0; m_cause = 0; m_count = 0;
        m_susp = 0; m_ack = 0; m_valid = 0; m_terr = 0; m_perr = 0;
    endtask

    function automatic bit held_too_long(input int age);
        return (age + 1) == int'(ACK_TO);
    endfunction

    task automatic log_wake();
        m_cause = (int'(slost) << 2) | (int'(brst) << 1) | int'(bni);
        m_valid = 1;
        if (m_count < CMAX) m_count = m_count + 1;
    endtask

    // Advance the reference by one clock edge using the current inputs.
    task automatic model_step();
        m_terr = 0;
        m_perr = 0;
        if (m_phase == 0) begin
            if (sus) begin
                m_phase = 1; m_susp = 1; m_cause = 0; m_valid = 0; m_age = 0;
            end
        end else if (m_phase == 1) begin
            if (act) begin m_phase = 2; m_susp = 0; end
            else if (held_too_long(m_age)) begin m_phase = 0; m_susp = 0; m_terr = 1; end
            else m_age++;
        end else if (m_phase == 2) begin
            if (!act) begin m_phase = 0; m_perr = 1; end
            else begin
                if (wreq) log_wake();
                if (ack) begin m_phase = 4; m_ack = 1; m_age = 0; end
                else if (wreq) m_phase = 3;
            end
        end else if (m_phase == 3) begin
            if (!act) begin m_phase = 0; m_perr = 1; end
            else if (ack) begin m_phase = 4; m_ack = 1; m_age = 0; end
        end else begin
            if (!act) begin m_phase = 0; m_ack = 0; end
            else if (held_too_long(m_age)) begin m_phase = 3; m_ack = 0; m_terr = 1; end
            else m_age++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 32'(o_state), 32'(m_phase));
        chk({tag, ".susp"},  32'(o_susp),  32'(m_susp));
        chk({tag, ".ack"},   32'(o_ack),   32'(m_ack));
        chk({tag, ".cause"}, 32'(o_cause), 32'(m_cause));
        chk({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
        chk({tag, ".count"}, 32'(o_count), 32'(m_count));
        chk({tag, ".terr"},  32'(o_terr),  32'(m_terr));
        chk({tag, ".perr"},  32'(o_perr),  32'(m_perr));
        chk({tag, ".excl"},  32'(o_susp & o_ack), 32'd0);
    endtask

    // Called at a negedge; drives pulses, clocks once, checks, returns at negedge.
    task automatic step(input logic s, input logic a, input string tag);
        sus = s;
        ack = a;
        model_step();
        @(posedge clk);
        #1;
        check_all(tag);
        @(negedge clk);
        sus = 1'b0;
        ack = 1'b0;
    endtask

    task automatic idle_n(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1;
        {sus, ack, act, wreq, bni, brst, slost} = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all("reset");
        rst = 1'b0;

        // Nominal loop
        step(1'b1, 1'b0, "nom_sus");
        idle_n(2, "nom_hold");
        chk("nom_susp_held", 32'(o_susp), 32'd1);
        act = 1'b1;
        step(1'b0, 1'b0, "nom_act");
        chk("nom_active", 32'(o_state), 32'd2);
        wreq = 1'b1; brst = 1'b1;
        step(1'b0, 1'b0, "nom_wake");
        chk("nom_cause", 32'(o_cause), 32'b010);
        chk("nom_count", 32'(o_count), 32'd1);
        brst = 1'b0;
        step(1'b0, 1'b1, "nom_ack");
        idle_n(1, "nom_ackhold");
        act = 1'b0; wreq = 1'b0;
        step(1'b0, 1'b0, "nom_drop");
        chk("nom_idle", 32'(o_state), 32'd0);

        // Suspend timeout
        step(1'b1, 1'b0, "sto_sus");
        idle_n(int'(ACK_TO) - 1, "sto_hold");
        chk("sto_still_req", 32'(o_susp), 32'd1);
        step(1'b0, 1'b0, "sto_fire");
        chk("sto_err", 32'(o_terr), 32'd1);
        chk("sto_count", 32'(o_count), 32'd1);
        step(1'b0, 1'b0, "sto_after");
        chk("sto_err_1cyc", 32'(o_terr), 32'd0);

        // Ack timeout and retry
        step(1'b1, 1'b0, "ato_sus");
        act = 1'b1;
        step(1'b0, 1'b0, "ato_act");
        wreq = 1'b1;
        step(1'b0, 1'b0, "ato_wake");
        step(1'b0, 1'b1, "ato_ack");
        idle_n(int'(ACK_TO), "ato_hold");
        chk("ato_err", 32'(o_terr), 32'd1);
        chk("ato_woken", 32'(o_state), 32'd3);
        step(1'b0, 1'b1, "ato_reack");
        act = 1'b0; wreq = 1'b0;
        step(1'b0, 1'b0, "ato_drop");
        chk("ato_count", 32'(o_count), 32'd2);

        // Simultaneous wake + ack, then response on the timeout edge
        step(1'b1, 1'b0, "sim_sus");
        act = 1'b1;
        step(1'b0, 1'b0, "sim_act");
        wreq = 1'b1; slost = 1'b1; bni = 1'b1;
        step(1'b0, 1'b1, "sim_both");
        chk("sim_cause", 32'(o_cause), 32'b101);
        chk("sim_state", 32'(o_state), 32'd4);
        slost = 1'b0; bni = 1'b0;
        idle_n(int'(ACK_TO) - 1, "sim_hold");
        act = 1'b0; wreq = 1'b0;
        step(1'b0, 1'b0, "sim_edge");
        chk("sim_no_err", 32'(o_terr), 32'd0);
        chk("sim_idle", 32'(o_state), 32'd0);

        // Protocol error
        step(1'b1, 1'b0, "pe_sus");
        act = 1'b1;
        step(1'b0, 1'b0, "pe_act");
        act = 1'b0;
        step(1'b0, 1'b0, "pe_drop");
        chk("pe_err", 32'(o_perr), 32'd1);
        step(1'b0, 1'b0, "pe_after");

        // Saturation: two more wake loops beyond count 3
        for (int k = 0; k < 2; k++) begin
            step(1'b1, 1'b0, "sat_sus");
            act = 1'b1;
            step(1'b0, 1'b0, "sat_act");
            wreq = 1'b1;
            step(1'b0, 1'b1, "sat_wake");
            act = 1'b0; wreq = 1'b0;
            step(1'b0, 1'b0, "sat_drop");
        end
        chk("sat_count", 32'(o_count), 32'(CMAX));

        // Ignored pulses: ack in IDLE
        step(1'b0, 1'b1, "ign_ack");
        chk("ign_idle", 32'(o_state), 32'd0);

        // Reset during ACK_WAIT
        step(1'b1, 1'b0, "rst_sus");
        act = 1'b1;
        step(1'b0, 1'b0, "rst_act");
        step(1'b0, 1'b1, "rst_ack");
        #1 rst = 1'b1;
        #1;
        model_reset();
        check_all("rst_async");
        #1 rst = 1'b0;
        act = 1'b0;
        @(negedge clk);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) act = ~act;
            wreq  = ($urandom_range(0, 5) == 0);
            bni   = 1'($urandom);
            brst  = 1'($urandom);
            slost = 1'($urandom);
            step(1'($urandom_range(0, 6) == 0), 1'($urandom_range(0, 6) == 0), "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
